// File: rtl/wb_arbiter_if.sv
// Bus bundle for the write-back arbiter: two MEM/WB lanes in, a single
// register-file write port and hazard-probe results out.
interface wb_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              regwrite1;
  logic              regwrite2;
  logic              memtoreg1;
  logic              memtoreg2;
  logic [DATA_W-1:0] readdata1;
  logic [DATA_W-1:0] readdata2;
  logic [DATA_W-1:0] resultalu1;
  logic [DATA_W-1:0] resultalu2;
  logic [4:0]        rd1;
  logic [4:0]        rd2;
  logic [4:0]        query_rs;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              stall;
  logic              pending_hit;
  logic [DATA_W-1:0] pending_data;

  modport slave (
    input  regwrite1, regwrite2, memtoreg1, memtoreg2,
    input  readdata1, readdata2, resultalu1, resultalu2,
    input  rd1, rd2, query_rs,
    output rf_we, rf_waddr, rf_wdata, stall, pending_hit, pending_data
  );

  modport master (
    output regwrite1, regwrite2, memtoreg1, memtoreg2,
    output readdata1, readdata2, resultalu1, resultalu2,
    output rd1, rd2, query_rs,
    input  rf_we, rf_waddr, rf_wdata, stall, pending_hit, pending_data
  );
endinterface

// File: rtl/wb_arbiter.sv
// Dual-lane write-back arbiter: merges two MEM/WB writes onto one register-file
// port through a 4-entry in-order deferred-write queue with forwarding probe.
module wb_arbiter (
  input  logic         clk,
  input  logic         reset,
  wb_arbiter_if.slave  bus
);
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int LIST_N = 8;

  logic [DATA_W-1:0] lane1_data_p0;
  logic [DATA_W-1:0] lane2_data_p0;
  logic              vld1_p0;
  logic              vld2_p0;

  logic [4:0]        lst_addr [LIST_N];
  logic [DATA_W-1:0] lst_data [LIST_N];
  logic [2:0]        lst_n;
  logic [2:0]        cnt_next;

  logic [4:0]        q_addr_p1 [DEPTH];
  logic [DATA_W-1:0] q_data_p1 [DEPTH];
  logic [2:0]        q_cnt_p1;
  logic              stall_p1;
  logic              rf_we_p1;
  logic [4:0]        rf_waddr_p1;
  logic [DATA_W-1:0] rf_wdata_p1;

  // Stage p0: lane select and keep decision; lane 2 wins a same-register pair
  always_comb begin
    lane1_data_p0 = bus.memtoreg1 ? bus.readdata1 : bus.resultalu1;
    lane2_data_p0 = bus.memtoreg2 ? bus.readdata2 : bus.resultalu2;
    vld2_p0 = !stall_p1 && bus.regwrite2 && (bus.rd2 != 5'd0);
    vld1_p0 = !stall_p1 && bus.regwrite1 && (bus.rd1 != 5'd0) &&
              !(vld2_p0 && (bus.rd1 == bus.rd2));
  end

  // Ordered list: stored entries oldest-first, then kept lane 1, then lane 2
  always_comb begin
    for (int i = 0; i < LIST_N; i++) begin
      lst_addr[i] = '0;
      lst_data[i] = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      lst_addr[i] = q_addr_p1[i];
      lst_data[i] = q_data_p1[i];
    end
    lst_n = q_cnt_p1;
    if (vld1_p0) begin
      lst_addr[lst_n] = bus.rd1;
      lst_data[lst_n] = lane1_data_p0;
      lst_n = lst_n + 3'd1;
    end
    if (vld2_p0) begin
      lst_addr[lst_n] = bus.rd2;
      lst_data[lst_n] = lane2_data_p0;
      lst_n = lst_n + 3'd1;
    end
    cnt_next = (lst_n == 3'd0) ? 3'd0 : lst_n - 3'd1;
  end

  // Stage p1: head of list retires to the register file, remainder shifts down
  always_ff @(posedge clk) begin
    if (reset) begin
      q_cnt_p1    <= 3'd0;
      stall_p1    <= 1'b0;
      rf_we_p1    <= 1'b0;
      rf_waddr_p1 <= '0;
      rf_wdata_p1 <= '0;
    end else begin
      q_cnt_p1    <= cnt_next;
      stall_p1    <= (cnt_next >= 3'd3);
      rf_we_p1    <= (lst_n != 3'd0);
      rf_waddr_p1 <= (lst_n != 3'd0) ? lst_addr[0] : 5'd0;
      rf_wdata_p1 <= (lst_n != 3'd0) ? lst_data[0] : '0;
    end
  end

  // Entry payload needs no reset: slots at or above q_cnt_p1 are never read
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      q_addr_p1[i] <= lst_addr[i+1];
      q_data_p1[i] <= lst_data[i+1];
    end
  end

  // Probe walks oldest to youngest so the last match wins
  always_comb begin
    bus.pending_hit  = 1'b0;
    bus.pending_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((3'(i) < q_cnt_p1) && (bus.query_rs != 5'd0) &&
          (q_addr_p1[i] == bus.query_rs)) begin
        bus.pending_hit  = 1'b1;
        bus.pending_data = q_data_p1[i];
      end
    end
  end

  assign bus.rf_we    = rf_we_p1;
  assign bus.rf_waddr = rf_waddr_p1;
  assign bus.rf_wdata = rf_wdata_p1;
  assign bus.stall    = stall_p1;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, hand-written stall/reset
// sequences, then random traffic against a queue-based reference model.
module tb_wb_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_arbiter_if #(.DATA_W(32)) bus ();

  wb_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        rw1; logic mt1; logic [4:0] rd1; logic [31:0] d1;
    logic        rw2; logic mt2; logic [4:0] rd2; logic [31:0] d2;
    logic [4:0]  qrs;
    logic        e_we; logic [4:0] e_addr; logic [31:0] e_data;
    logic        e_stall; logic e_hit; logic [31:0] e_pd;
  } vec_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  vec_t tbl [15];

  ent_t        mq [$];
  logic        m_stall;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Inputs are driven 1 time unit after the edge; the memtoreg-unselected
  // source carries the complement so a wrong mux choice is visible.
  task automatic drive(input logic rw1, input logic mt1, input logic [4:0] rd1, input logic [31:0] d1,
                       input logic rw2, input logic mt2, input logic [4:0] rd2, input logic [31:0] d2,
                       input logic [4:0] qrs);
    bus.regwrite1  = rw1; bus.memtoreg1 = mt1; bus.rd1 = rd1;
    bus.readdata1  = mt1 ? d1 : ~d1;
    bus.resultalu1 = mt1 ? ~d1 : d1;
    bus.regwrite2  = rw2; bus.memtoreg2 = mt2; bus.rd2 = rd2;
    bus.readdata2  = mt2 ? d2 : ~d2;
    bus.resultalu2 = mt2 ? ~d2 : d2;
    bus.query_rs   = qrs;
  endtask

  task automatic idle(input logic [4:0] qrs);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, qrs);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rf(input string nm, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({nm, ".we"},   32'(bus.rf_we),    32'(we));
    chk({nm, ".addr"}, 32'(bus.rf_waddr), 32'(a));
    chk({nm, ".data"}, bus.rf_wdata,      d);
  endtask

  // Reference model: plain list semantics of the arbiter on an SV queue
  task automatic model_step(input logic rst, input logic rw1, input logic [4:0] rd1, input logic [31:0] d1,
                            input logic rw2, input logic [4:0] rd2, input logic [31:0] d2);
    ent_t lst [$];
    logic k1, k2;
    if (rst) begin
      mq.delete(); m_stall = 1'b0; m_we = 1'b0; m_addr = '0; m_data = '0;
      return;
    end
    lst = mq;
    if (!m_stall) begin
      k2 = rw2 && (rd2 != 0);
      k1 = rw1 && (rd1 != 0) && !(k2 && rd1 == rd2);
      if (k1) lst.push_back('{a: rd1, d: d1});
      if (k2) lst.push_back('{a: rd2, d: d2});
    end
    if (lst.size() > 0) begin
      ent_t h;
      h = lst.pop_front();
      m_we = 1'b1; m_addr = h.a; m_data = h.d;
    end else begin
      m_we = 1'b0; m_addr = '0; m_data = '0;
    end
    mq = lst;
    m_stall = (mq.size() >= 3);
  endtask

  task automatic model_probe(input logic [4:0] qrs, output logic hit, output logic [31:0] pd);
    hit = 1'b0; pd = '0;
    foreach (mq[i]) if (qrs != 0 && mq[i].a == qrs) begin hit = 1'b1; pd = mq[i].d; end
  endtask

  initial begin
    logic        hit;
    logic [31:0] pd;

    //            rw1 mt1 rd1  d1           rw2 mt2 rd2  d2           qrs  we a  data        st hit pd
    tbl[0]  = '{1, 0, 5'd5, 32'h11,     0, 0, 5'd0, 32'h0,     5'd5, 1, 5'd5, 32'h11,  0, 0, 32'h0};
    tbl[1]  = '{0, 0, 5'd0, 32'h0,      0, 0, 5'd0, 32'h0,     5'd5, 0, 5'd0, 32'h0,   0, 0, 32'h0};
    tbl[2]  = '{1, 0, 5'd3, 32'hA,      1, 1, 5'd4, 32'hB,     5'd4, 1, 5'd3, 32'hA,   0, 1, 32'hB};
    tbl[3]  = '{0, 0, 5'd0, 32'h0,      0, 0, 5'd0, 32'h0,     5'd4, 1, 5'd4, 32'hB,   0, 0, 32'h0};
    tbl[4]  = '{0, 0, 5'd0, 32'h0,      0, 0, 5'd0, 32'h0,     5'd4, 0, 5'd0, 32'h0,   0, 0, 32'h0};
    tbl[5]  = '{1, 0, 5'd7, 32'h1,      1, 0, 5'd7, 32'h2,     5'd7, 1, 5'd7, 32'h2,   0, 0, 32'h0};
    tbl[6]  = '{0, 0, 5'd0, 32'h0,      0, 0, 5'd0, 32'h0,     5'd7, 0, 5'd0, 32'h0,   0, 0, 32'h0};
    tbl[7]  = '{1, 1, 5'd0, 32'h55,     1, 0, 5'd0, 32'h66,    5'd0, 0, 5'd0, 32'h0,   0, 0, 32'h0};
    tbl[8]  = '{0, 0, 5'd0, 32'h0,      0, 0, 5'd0, 32'h0,     5'd0, 0, 5'd0, 32'h0,   0, 0, 32'h0};
    tbl[9]  = '{1, 0, 5'd1, 32'h100,    1, 0, 5'd2, 32'h200,   5'd2, 1, 5'd1, 32'h100, 0, 1, 32'h200};
    tbl[10] = '{1, 1, 5'd3, 32'h300,    1, 0, 5'd9, 32'h5,     5'd9, 1, 5'd2, 32'h200, 0, 1, 32'h5};
    tbl[11] = '{1, 0, 5'd9, 32'h6,      0, 0, 5'd0, 32'h0,     5'd9, 1, 5'd3, 32'h300, 0, 1, 32'h6};
    tbl[12] = '{0, 0, 5'd0, 32'h0,      0, 0, 5'd0, 32'h0,     5'd9, 1, 5'd9, 32'h5,   0, 1, 32'h6};
    tbl[13] = '{0, 0, 5'd0, 32'h0,      0, 0, 5'd0, 32'h0,     5'd9, 1, 5'd9, 32'h6,   0, 0, 32'h0};
    tbl[14] = '{0, 0, 5'd0, 32'h0,      0, 0, 5'd0, 32'h0,     5'd0, 0, 5'd0, 32'h0,   0, 0, 32'h0};

    // Reset state, with lanes active to show they are discarded
    reset = 1'b1;
    drive(1'b1, 1'b0, 5'd6, 32'h77, 1'b1, 1'b0, 5'd8, 32'h88, 5'd6);
    tick(); tick();
    chk_rf("reset", 1'b0, 5'd0, 32'h0);
    chk("reset.stall", 32'(bus.stall), 32'h0);
    chk("reset.hit",   32'(bus.pending_hit), 32'h0);
    reset = 1'b0;
    idle(5'd0);
    tick();
    chk("reset.nowrite", 32'(bus.rf_we), 32'h0);

    foreach (tbl[i]) begin
      drive(tbl[i].rw1, tbl[i].mt1, tbl[i].rd1, tbl[i].d1,
            tbl[i].rw2, tbl[i].mt2, tbl[i].rd2, tbl[i].d2, tbl[i].qrs);
      tick();
      chk_rf($sformatf("vec%0d", i), tbl[i].e_we, tbl[i].e_addr, tbl[i].e_data);
      chk($sformatf("vec%0d.stall", i), 32'(bus.stall),       32'(tbl[i].e_stall));
      chk($sformatf("vec%0d.hit", i),   32'(bus.pending_hit), 32'(tbl[i].e_hit));
      chk($sformatf("vec%0d.pd", i),    bus.pending_data,     tbl[i].e_pd);
    end

    // Back-to-back dual writes fill the queue to 3 and raise stall
    drive(1, 0, 5'd1, 32'h101, 1, 0, 5'd2, 32'h102, 5'd0); tick();
    chk_rf("b2b1", 1, 5'd1, 32'h101); chk("b2b1.stall", 32'(bus.stall), 0);
    drive(1, 0, 5'd3, 32'h103, 1, 0, 5'd4, 32'h104, 5'd0); tick();
    chk_rf("b2b2", 1, 5'd2, 32'h102); chk("b2b2.stall", 32'(bus.stall), 0);
    drive(1, 0, 5'd5, 32'h105, 1, 0, 5'd6, 32'h106, 5'd6); tick();
    chk_rf("b2b3", 1, 5'd3, 32'h103); chk("b2b3.stall", 32'(bus.stall), 1);
    chk("b2b3.pd", bus.pending_data, 32'h106);
    drive(1, 0, 5'd7, 32'h107, 1, 0, 5'd8, 32'h108, 5'd7); tick();
    chk_rf("b2b4", 1, 5'd4, 32'h104); chk("b2b4.stall", 32'(bus.stall), 0);
    chk("b2b4.ignored", 32'(bus.pending_hit), 0);
    idle(5'd0); tick();
    chk_rf("b2b5", 1, 5'd5, 32'h105);
    tick();
    chk_rf("b2b6", 1, 5'd6, 32'h106);
    tick();
    chk_rf("b2b7", 0, 5'd0, 32'h0);

    // Reset with three queued entries: nothing queued may retire afterwards
    drive(1, 0, 5'd1, 32'h201, 1, 0, 5'd2, 32'h202, 5'd0); tick();
    drive(1, 0, 5'd3, 32'h203, 1, 0, 5'd4, 32'h204, 5'd0); tick();
    drive(1, 0, 5'd5, 32'h205, 1, 0, 5'd6, 32'h206, 5'd4); tick();
    chk("rq.stall", 32'(bus.stall), 1);
    chk("rq.hit",   32'(bus.pending_hit), 1);
    reset = 1'b1;
    drive(1, 0, 5'd20, 32'h220, 1, 0, 5'd21, 32'h221, 5'd4); tick();
    reset = 1'b0;
    chk("rq.we",    32'(bus.rf_we), 0);
    chk("rq.stall0", 32'(bus.stall), 0);
    chk("rq.hit0",  32'(bus.pending_hit), 0);
    idle(5'd4);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("rq.drain%0d", k), 32'(bus.rf_we), 0);
    end

    // Random traffic against the reference model
    reset = 1'b1; idle(5'd0); tick();
    model_step(1'b1, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic        rst, rw1, rw2, mt1, mt2;
      logic [4:0]  rd1, rd2, qrs;
      logic [31:0] d1, d2;
      rst = ($urandom_range(0, 49) == 0);
      rw1 = ($urandom_range(0, 3) != 0); rw2 = ($urandom_range(0, 3) != 0);
      mt1 = 1'($urandom);  mt2 = 1'($urandom);
      rd1 = 5'($urandom_range(0, 7)); rd2 = 5'($urandom_range(0, 7));
      qrs = 5'($urandom_range(0, 7));
      d1 = $urandom; d2 = $urandom;
      reset = rst;
      drive(rw1, mt1, rd1, d1, rw2, mt2, rd2, d2, qrs);
      model_step(rst, rw1, rd1, d1, rw2, rd2, d2);
      tick();
      model_probe(qrs, hit, pd);
      if (bus.rf_we !== m_we || bus.rf_waddr !== m_addr || bus.rf_wdata !== m_data) begin
        chk_rf($sformatf("rnd%0d", n), m_we, m_addr, m_data);
      end else begin
        checks++;
      end
      chk($sformatf("rnd%0d.stall", n), 32'(bus.stall),       32'(m_stall));
      chk($sformatf("rnd%0d.hit", n),   32'(bus.pending_hit), 32'(hit));
      chk($sformatf("rnd%0d.pd", n),    bus.pending_data,     pd);
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 DEPTH, 4, deferred-write queue entries (fixed; other values not supported).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 regwrite1 / regwrite2  input  1  lane 1 / lane 2 write request from MEM/WB; lane 1 older in program order.
REQ-005 memtoreg1 / memtoreg2  input  1  selects readdata (1) or resultalu (0) per lane.
REQ-006 readdata1 / readdata2  input  32  load data per lane.
REQ-007 resultalu1 / resultalu2  input  32  ALU result per lane.
REQ-008 rd1 / rd2  input  5  destination register per lane.
REQ-009 query_rs  input  5  register address probed by hazard unit.
REQ-010 rf_we  output  1  registered single register-file write enable.
REQ-011 rf_waddr  output  5  registered write address.
REQ-012 rf_wdata  output  32  registered write data.
REQ-013 stall  output  1  registered; high = upstream holds lanes, inputs ignored.
REQ-014 pending_hit  output  1  combinational; query_rs matches a stored queue entry.
REQ-015 pending_data  output  32  combinational; data of youngest matching entry, 0 if no hit.

Function
REQ-016 Lane data = memtoreg ? readdata : resultalu, per lane.
REQ-017 Lane kept only if stall low, regwrite high, rd nonzero; rd=0 writes dropped silently.
REQ-018 Both lanes kept with rd1==rd2: lane 1 dropped (WAW), only lane 2 kept.
REQ-019 Ordered list each cycle: stored entries (oldest first), then kept lane 1, then kept lane 2.
REQ-020 Each cycle, first list element (if any) loads rf_we=1/rf_waddr/rf_wdata; if list empty, rf_we=0, addr/data hold 0.
REQ-021 Remaining list elements stored in queue in order; count_next = count + kept - pop, range 0..4.
REQ-022 Latency: kept write with empty queue appears on rf_* the next cycle; lane 2 of a pair one cycle later.
REQ-023 stall registered: stall <= (count_next >= 3); stall low guarantees count <= 2, so no overflow is possible.
REQ-024 While stall high, lanes ignored regardless of regwrite; queue drains one entry per cycle.
REQ-025 Queue never pushes beyond 4; never pops when empty (underflow impossible by construction).
REQ-026 pending_hit ignores query_rs=0; considers stored entries only, not the rf_* register nor same-cycle inputs.
REQ-027 Multiple matching entries: pending_data from youngest (last enqueued).
REQ-028 Program order preserved: writes to rf never reordered relative to arrival order.

Reset
REQ-029 On reset: rf_we=0, rf_waddr=0, rf_wdata=0, stall=0, queue count=0, all entries invalid; inputs that cycle discarded.
REQ-030 Reset mid-operation discards all queued writes; pending_hit=0 the following cycle.

Verification
REQ-031 Single write: regwrite1=1, rd1=5, memtoreg1=0, resultalu1=0x11 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x11; cycle after rf_we=0.
REQ-032 Dual write: rd1=3 data 0xA, rd2=4 data 0xB (memtoreg2=1, readdata2=0xB) -> rf writes r3=0xA then r4=0xB on consecutive cycles; pending_hit=1 for query_rs=4 in between.
REQ-033 WAW: rd1=rd2=7, data 0x1/0x2 -> only one write, r7=0x2; rd=0 lanes produce no write.
REQ-034 Back-to-back dual writes for 3 cycles -> stall rises once count reaches 3; lanes presented while stall high produce no writes; all accepted writes retire in order; stall drops when count <= 2.
REQ-035 Queue holding r9=0x5 then r9=0x6 -> pending_hit=1, pending_data=0x6.
REQ-036 Reset asserted with 3 queued entries -> next cycle rf_we=0, stall=0, pending_hit=0; no queued write ever retires.
